cp0_exc_unit: RTL and testbench
===============================

CP0_EXC_UNIT -- requirements
Module: cp0_exc_unit

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high.
REQ-002 SHALL have port exc input exception_t: the pipeline's committed exception record (valid, location, pc, in_delay_slot, code, badvaddr).
REQ-003 SHALL have port eret input 1: ERET committed this cycle.
REQ-004 SHALL have port ext_int input 6: hardware interrupt lines, level-sensitive, already synchronous to clk.
REQ-005 SHALL have ports raddr input 5 and rdata output 32: MFC0 read, combinational.
REQ-006 SHALL have ports we input 1, waddr input 5 and wdata input 32: MTC0 write.
REQ-007 SHALL have ports redirect_valid output 1, redirect_pc output 32 and flush output 1: fetch redirect and pipeline flush.
REQ-008 SHALL have port int_pending output 1: an enabled interrupt is pending; the pipeline tags its next commit with CODE_INT.

Function
REQ-009 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14); reads of other indices SHALL return 0.
REQ-010 Status: BEV bit22 hardwired 1; IM[15:8], EXL[1] and IE[0] writable; all other bits read 0.
REQ-011 Cause: BD[31], TI[30], IP[15:8] and ExcCode[6:2]; only IP[9:8] are MTC0-writable.
REQ-012 Cause.IP[15:10] SHALL equal ext_int[5:0] each cycle, with IP[15] OR-ed with TI.
REQ-013 FSM states: IDLE and REDIRECT.
REQ-014 In IDLE, exc.valid=1 SHALL be accepted and the FSM SHALL go to REDIRECT next cycle.
REQ-015 In IDLE, eret=1 with exc.valid=0 SHALL be accepted and the FSM SHALL go to REDIRECT.
REQ-016 REDIRECT SHALL last exactly 1 cycle and then return to IDLE.
REQ-017 In REDIRECT, redirect_valid=1 and flush=1; exc, eret and we SHALL be ignored.
REQ-018 Priority within one IDLE cycle: exception > eret > MTC0; the lower-priority event SHALL be dropped.
REQ-019 Exception accept with Status.EXL=0: EPC <= in_delay_slot ? pc-4 : pc; BD <= in_delay_slot.
REQ-020 Exception accept with Status.EXL=1: EPC and BD SHALL be left unchanged.
REQ-021 Every exception accept: ExcCode <= code and EXL <= 1.
REQ-022 Every exception accept: BadVAddr <= badvaddr only for CODE_ADEL, ADES, TLBL, TLBS and MOD.
REQ-023 For an accepted exception, redirect_pc = EXC_ENTRY (0xbfc0_0380).
REQ-024 For an accepted ERET, redirect_pc = EPC value at the accept edge, and EXL SHALL be cleared.
REQ-025 Latency: accept edge -> redirect_valid high during the following cycle, with redirect_pc registered.
REQ-026 Count SHALL increment by 1 every second clk cycle, wrapping at 2^32 to 0.
REQ-027 TI SHALL set when Count==Compare and stay set until an MTC0 write to Compare, which clears it the cycle after the write.
REQ-028 MTC0 to Count SHALL load wdata and restart the half-rate phase.
REQ-029 MTC0 write and Count increment in the same cycle: the write wins.
REQ-030 int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational from registered state, and SHALL be forced 0 in REDIRECT.
REQ-031 rdata SHALL reflect state before the edge; MTC0 write followed by a read the next cycle returns the new value.

Reset
REQ-032 While reset=1: state=IDLE, Status=0x0040_0000, Cause.BD/TI/IP[9:8]/ExcCode=0, EPC=0, BadVAddr=0, Count=0, Compare=0, half-rate phase=0.
REQ-033 While reset=1, redirect_valid=0, flush=0, redirect_pc=0 and int_pending=0.
REQ-034 Reset asserted in REDIRECT SHALL abort the redirect immediately, without waiting for a clock edge.

Structure
REQ-035 CP0 index constants (CP0_BADVADDR, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC) and the FSM state enum SHALL live in exception_pkg, beside exception_t and EXC_ENTRY.
REQ-036 Count, Compare, the half-rate phase and TI SHALL be one sub-module, cp0_timer.

Verification
REQ-037 Test 1: exc{valid=1, pc=0x8000_1004, in_delay_slot=1, code=CODE_ADEL, badvaddr=0x1} with EXL=0 -> next cycle redirect_valid=1, redirect_pc=0xbfc0_0380; EPC=0x8000_1000; BD=1; ExcCode=4; BadVAddr=0x1; EXL=1.
REQ-038 Test 2: second exception code=CODE_SYS, pc=0x8000_2000 while EXL=1 -> EPC stays 0x8000_1000; ExcCode=8; BadVAddr unchanged.
REQ-039 Test 3: eret=1 -> redirect_pc=0x8000_1000 and EXL=0; exc.valid=1 and eret=1 in the same cycle -> exception taken, redirect to 0xbfc0_0380.
REQ-040 Test 4: Compare=10, Count=0, Status=0x0040_8001 -> TI=1 and int_pending=1 at cycle ~20; MTC0 Compare -> TI=0 and int_pending=0.
REQ-041 Test 5: exc.valid=1 during REDIRECT -> ignored, with no register change and no second redirect; MTC0 Status together with an exception -> write dropped.
REQ-042 Test 6: reset pulse asserted mid-REDIRECT -> redirect_valid=0 immediately; all registers equal REQ-032 values.

Source files
------------

// File: rtl/cp0_exc_unit_pkg.sv
// Shared types and constants for the CP0 exception unit: the committed
// exception record, exception codes, CP0 register indices and FSM states.
package exception_pkg;

   localparam logic [31:0] EXC_ENTRY = 32'hbfc0_0380;

   localparam logic [4:0] CODE_INT  = 5'd0;
   localparam logic [4:0] CODE_MOD  = 5'd1;
   localparam logic [4:0] CODE_TLBL = 5'd2;
   localparam logic [4:0] CODE_TLBS = 5'd3;
   localparam logic [4:0] CODE_ADEL = 5'd4;
   localparam logic [4:0] CODE_ADES = 5'd5;
   localparam logic [4:0] CODE_SYS  = 5'd8;
   localparam logic [4:0] CODE_BP   = 5'd9;
   localparam logic [4:0] CODE_RI   = 5'd10;
   localparam logic [4:0] CODE_OV   = 5'd12;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } cp0_state_e;

   // location identifies the pipeline stage that raised the exception;
   // CP0 itself does not use it.
   typedef struct packed {
      logic        valid;
      logic [1:0]  location;
      logic [31:0] pc;
      logic        in_delay_slot;
      logic [4:0]  code;
      logic [31:0] badvaddr;
   } exception_t;

   // Address-error and TLB exceptions are the only ones carrying a faulting address.
   function automatic logic code_has_badvaddr(input logic [4:0] code);
      return (code == CODE_ADEL) || (code == CODE_ADES) || (code == CODE_TLBL) ||
             (code == CODE_TLBS) || (code == CODE_MOD);
   endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 bus: commit-side exception/eret, MFC0/MTC0 access,
// interrupt lines and the fetch redirect / flush outputs.
interface cp0_exc_unit_if;
   exception_pkg::exception_t exc;
   logic        eret;
   logic [5:0]  ext_int;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        int_pending;

   modport master (
      output exc, eret, ext_int, raddr, we, waddr, wdata,
      input  rdata, redirect_valid, redirect_pc, flush, int_pending
   );

   modport slave (
      input  exc, eret, ext_int, raddr, we, waddr, wdata,
      output rdata, redirect_valid, redirect_pc, flush, int_pending
   );
endinterface

// File: rtl/cp0_exc_unit_timer.sv
// CP0 Count/Compare timer. Count advances once every two clk cycles; TI is
// sticky from a Count==Compare match until software rewrites Compare.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        phase_q, phase_d;
   logic        ti_q, ti_d;

   // Next-state: software writes win over the half-rate increment and the match.
   always_comb begin
      count_d   = count_q;
      phase_d   = ~phase_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_we_i) begin
         count_d = wdata_i;
         phase_d = 1'b0;
      end else if (phase_q) begin
         count_d = count_q + 32'd1;
      end
      if (compare_we_i) begin
         compare_d = wdata_i;
         ti_d      = 1'b0;
      end else if (count_q == compare_q) begin
         ti_d = 1'b1;
      end
   end

   // Timer state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '0;
         phase_q   <= 1'b0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         phase_q   <= phase_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: Status/Cause/EPC/BadVAddr, exception and ERET
// acceptance, and a one-cycle fetch redirect with pipeline flush.
//
// state       | meaning
// ST_IDLE     | accepting exception / eret / MTC0, in that priority
// ST_REDIRECT | redirect_valid and flush high for one cycle; inputs ignored
module cp0_exc_unit
   import exception_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   cp0_exc_unit_if.slave   bus
);

   cp0_state_e  state_q, state_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [1:0]  ipsw_q, ipsw_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        wr_take;
   logic [31:0] count, compare;
   logic        ti;
   logic [7:0]  ip;
   logic [31:0] status_rd, cause_rd;
   logic        unused_location;

   assign unused_location = ^bus.exc.location;

   cp0_timer u_timer (
      .clk          (clk),
      .reset        (reset),
      .count_we_i   (wr_take && (bus.waddr == CP0_COUNT)),
      .compare_we_i (wr_take && (bus.waddr == CP0_COMPARE)),
      .wdata_i      (bus.wdata),
      .count_o      (count),
      .compare_o    (compare),
      .ti_o         (ti)
   );

   assign ip        = {bus.ext_int[5] | ti, bus.ext_int[4:0], ipsw_q};
   assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_rd  = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};

   // Next-state and register updates; exception beats eret beats MTC0.
   always_comb begin
      state_d       = state_q;
      im_d          = im_q;
      exl_d         = exl_q;
      ie_d          = ie_q;
      bd_d          = bd_q;
      ipsw_d        = ipsw_q;
      exccode_d     = exccode_q;
      epc_d         = epc_q;
      badvaddr_d    = badvaddr_q;
      redirect_pc_d = redirect_pc_q;
      wr_take       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.exc.valid) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = EXC_ENTRY;
               exccode_d     = bus.exc.code;
               exl_d         = 1'b1;
               if (!exl_q) begin
                  epc_d = bus.exc.in_delay_slot ? bus.exc.pc - 32'd4 : bus.exc.pc;
                  bd_d  = bus.exc.in_delay_slot;
               end
               if (code_has_badvaddr(bus.exc.code)) badvaddr_d = bus.exc.badvaddr;
            end else if (bus.eret) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = epc_q;
               exl_d         = 1'b0;
            end else if (bus.we) begin
               wr_take = 1'b1;
               case (bus.waddr)
                  CP0_STATUS: begin
                     im_d  = bus.wdata[15:8];
                     exl_d = bus.wdata[1];
                     ie_d  = bus.wdata[0];
                  end
                  CP0_CAUSE: ipsw_d = bus.wdata[9:8];
                  CP0_EPC:   epc_d  = bus.wdata;
                  default: ;
               endcase
            end
         end
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // State and architectural register storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         im_q          <= '0;
         exl_q         <= 1'b0;
         ie_q          <= 1'b0;
         bd_q          <= 1'b0;
         ipsw_q        <= '0;
         exccode_q     <= '0;
         epc_q         <= '0;
         badvaddr_q    <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         im_q          <= im_d;
         exl_q         <= exl_d;
         ie_q          <= ie_d;
         bd_q          <= bd_d;
         ipsw_q        <= ipsw_d;
         exccode_q     <= exccode_d;
         epc_q         <= epc_d;
         badvaddr_q    <= badvaddr_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // MFC0 read mux; unimplemented indices read zero.
   always_comb begin
      bus.rdata = '0;
      case (bus.raddr)
         CP0_BADVADDR: bus.rdata = badvaddr_q;
         CP0_COUNT:    bus.rdata = count;
         CP0_COMPARE:  bus.rdata = compare;
         CP0_STATUS:   bus.rdata = status_rd;
         CP0_CAUSE:    bus.rdata = cause_rd;
         CP0_EPC:      bus.rdata = epc_q;
         default:      bus.rdata = '0;
      endcase
   end

   assign bus.redirect_valid = (state_q == ST_REDIRECT);
   assign bus.flush          = (state_q == ST_REDIRECT);
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.int_pending    = (state_q == ST_IDLE) & ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;
   import exception_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [31:0] rd;

   cp0_exc_unit_if bus();

   cp0_exc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
      tick;
      bus.we = 1'b0;
   endtask

   task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
      bus.raddr = a;
      #1;
      d = bus.rdata;
   endtask

   task automatic drive_exc(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                            input logic [31:0] bva);
      bus.exc.valid = 1'b1; bus.exc.location = 2'd1; bus.exc.pc = pc;
      bus.exc.in_delay_slot = ds; bus.exc.code = code; bus.exc.badvaddr = bva;
   endtask

   task automatic check_reset_regs(input string tag);
      mfc0(CP0_STATUS, rd);   checks++; if (rd !== 32'h0040_0000) begin errors++; $display("FAIL %s status: got %h exp %h", tag, rd, 32'h0040_0000); end
      mfc0(CP0_CAUSE, rd);    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s cause: got %h exp 0", tag, rd); end
      mfc0(CP0_EPC, rd);      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s epc: got %h exp 0", tag, rd); end
      mfc0(CP0_BADVADDR, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s badvaddr: got %h exp 0", tag, rd); end
      mfc0(CP0_COUNT, rd);    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s count: got %h exp 0", tag, rd); end
      mfc0(CP0_COMPARE, rd);  checks++; if (rd !== 32'h0) begin errors++; $display("FAIL %s compare: got %h exp 0", tag, rd); end
      checks++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL %s redirect/flush: got %b%b exp 00", tag, bus.redirect_valid, bus.flush); end
      checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL %s redirect_pc: got %h exp 0", tag, bus.redirect_pc); end
      checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL %s int_pending: got %b exp 0", tag, bus.int_pending); end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick; tick;
      check_reset_regs("reset");
      mfc0(5'd3, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unimpl_read: got %h exp 0", rd); end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_exc_first;
      drive_exc(32'h8000_1004, 1'b1, CODE_ADEL, 32'h1);
      tick;
      bus.exc = '0;
      checks++; if (bus.redirect_valid !== 1'b1 || bus.flush !== 1'b1) begin errors++; $display("FAIL exc1 redirect/flush: got %b%b exp 11", bus.redirect_valid, bus.flush); end
      checks++; if (bus.redirect_pc !== 32'hbfc0_0380) begin errors++; $display("FAIL exc1 redirect_pc: got %h exp bfc00380", bus.redirect_pc); end
      checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL exc1 int_pending: got %b exp 0", bus.int_pending); end
      tick;
      checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL exc1 one_cycle: got %b exp 0", bus.redirect_valid); end
      mfc0(CP0_EPC, rd);      checks++; if (rd !== 32'h8000_1000) begin errors++; $display("FAIL exc1 epc: got %h exp 80001000", rd); end
      mfc0(CP0_CAUSE, rd);
      checks++; if (rd[31] !== 1'b1) begin errors++; $display("FAIL exc1 bd: got %b exp 1", rd[31]); end
      checks++; if (rd[6:2] !== 5'd4) begin errors++; $display("FAIL exc1 exccode: got %0d exp 4", rd[6:2]); end
      mfc0(CP0_BADVADDR, rd); checks++; if (rd !== 32'h1) begin errors++; $display("FAIL exc1 badvaddr: got %h exp 1", rd); end
      mfc0(CP0_STATUS, rd);   checks++; if (rd !== 32'h0040_0002) begin errors++; $display("FAIL exc1 status: got %h exp 00400002", rd); end
   endtask

   task automatic test_exc_nested;
      drive_exc(32'h8000_2000, 1'b0, CODE_SYS, 32'hdead_beef);
      tick;
      bus.exc = '0;
      checks++; if (bus.redirect_pc !== 32'hbfc0_0380) begin errors++; $display("FAIL exc2 redirect_pc: got %h exp bfc00380", bus.redirect_pc); end
      tick;
      mfc0(CP0_EPC, rd);      checks++; if (rd !== 32'h8000_1000) begin errors++; $display("FAIL exc2 epc: got %h exp 80001000", rd); end
      mfc0(CP0_CAUSE, rd);
      checks++; if (rd[6:2] !== 5'd8) begin errors++; $display("FAIL exc2 exccode: got %0d exp 8", rd[6:2]); end
      checks++; if (rd[31] !== 1'b1) begin errors++; $display("FAIL exc2 bd: got %b exp 1", rd[31]); end
      mfc0(CP0_BADVADDR, rd); checks++; if (rd !== 32'h1) begin errors++; $display("FAIL exc2 badvaddr: got %h exp 1", rd); end
   endtask

   task automatic test_eret_priority;
      bus.eret = 1'b1;
      tick;
      bus.eret = 1'b0;
      checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL eret redirect_valid: got %b exp 1", bus.redirect_valid); end
      checks++; if (bus.redirect_pc !== 32'h8000_1000) begin errors++; $display("FAIL eret redirect_pc: got %h exp 80001000", bus.redirect_pc); end
      tick;
      mfc0(CP0_STATUS, rd); checks++; if (rd !== 32'h0040_0000) begin errors++; $display("FAIL eret status: got %h exp 00400000", rd); end
      drive_exc(32'h8000_3000, 1'b0, CODE_BP, 32'h0);
      bus.eret = 1'b1;
      tick;
      bus.exc = '0; bus.eret = 1'b0;
      checks++; if (bus.redirect_pc !== 32'hbfc0_0380) begin errors++; $display("FAIL exc_over_eret redirect_pc: got %h exp bfc00380", bus.redirect_pc); end
      tick;
      mfc0(CP0_EPC, rd);    checks++; if (rd !== 32'h8000_3000) begin errors++; $display("FAIL exc_over_eret epc: got %h exp 80003000", rd); end
      mfc0(CP0_STATUS, rd); checks++; if (rd !== 32'h0040_0002) begin errors++; $display("FAIL exc_over_eret status: got %h exp 00400002", rd); end
   endtask

   task automatic test_count;
      mtc0(CP0_COUNT, 32'hffff_ffff);
      mfc0(CP0_COUNT, rd); checks++; if (rd !== 32'hffff_ffff) begin errors++; $display("FAIL count_load: got %h exp ffffffff", rd); end
      tick;
      mfc0(CP0_COUNT, rd); checks++; if (rd !== 32'hffff_ffff) begin errors++; $display("FAIL count_half_rate: got %h exp ffffffff", rd); end
      // phase is now 1: this write coincides with an increment edge and must win
      mtc0(CP0_COUNT, 32'h0000_0100);
      mfc0(CP0_COUNT, rd); checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL count_write_wins: got %h exp 00000100", rd); end
      tick;
      mfc0(CP0_COUNT, rd); checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL count_phase_restart: got %h exp 00000100", rd); end
      tick;
      mfc0(CP0_COUNT, rd); checks++; if (rd !== 32'h0000_0101) begin errors++; $display("FAIL count_inc: got %h exp 00000101", rd); end
      mtc0(CP0_COUNT, 32'hffff_ffff);
      tick; tick;
      mfc0(CP0_COUNT, rd); checks++; if (rd !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h exp 0", rd); end
   endtask

   task automatic test_timer_irq;
      int n;
      mtc0(CP0_STATUS, 32'h0040_8001);
      mtc0(CP0_COUNT, 32'h0);
      mtc0(CP0_COMPARE, 32'd10);
      mfc0(CP0_CAUSE, rd); checks++; if (rd[30] !== 1'b0) begin errors++; $display("FAIL ti_cleared_initially: got %b exp 0", rd[30]); end
      n = 0;
      while (n < 40) begin
         tick;
         n++;
         mfc0(CP0_CAUSE, rd);
         if (rd[30] === 1'b1) break;
      end
      checks++; if (n != 20) begin errors++; $display("FAIL ti_latency: got %0d cycles exp 20", n); end
      checks++; if (rd[15] !== 1'b1) begin errors++; $display("FAIL ti_ip7: got %b exp 1", rd[15]); end
      checks++; if (bus.int_pending !== 1'b1) begin errors++; $display("FAIL ti_int_pending: got %b exp 1", bus.int_pending); end
      mtc0(CP0_COMPARE, 32'hffff_0000);
      mfc0(CP0_CAUSE, rd); checks++; if (rd[30] !== 1'b0) begin errors++; $display("FAIL ti_clear: got %b exp 0", rd[30]); end
      checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL ti_clear int_pending: got %b exp 0", bus.int_pending); end
   endtask

   task automatic test_redirect_ignore;
      drive_exc(32'h8000_4000, 1'b0, CODE_RI, 32'h0);
      tick;
      drive_exc(32'h8000_5000, 1'b0, CODE_OV, 32'h0);
      bus.we = 1'b1; bus.waddr = CP0_STATUS; bus.wdata = 32'h0;
      tick;
      bus.exc = '0; bus.we = 1'b0;
      checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL redirect_ignore second_redirect: got %b exp 0", bus.redirect_valid); end
      mfc0(CP0_EPC, rd);    checks++; if (rd !== 32'h8000_4000) begin errors++; $display("FAIL redirect_ignore epc: got %h exp 80004000", rd); end
      mfc0(CP0_CAUSE, rd);  checks++; if (rd[6:2] !== 5'd10) begin errors++; $display("FAIL redirect_ignore exccode: got %0d exp 10", rd[6:2]); end
      mfc0(CP0_STATUS, rd); checks++; if (rd !== 32'h0040_8003) begin errors++; $display("FAIL redirect_ignore status: got %h exp 00408003", rd); end
      drive_exc(32'h8000_6000, 1'b0, CODE_SYS, 32'h0);
      bus.we = 1'b1; bus.waddr = CP0_STATUS; bus.wdata = 32'h0;
      tick;
      bus.exc = '0; bus.we = 1'b0;
      tick;
      mfc0(CP0_STATUS, rd); checks++; if (rd !== 32'h0040_8003) begin errors++; $display("FAIL exc_over_mtc0 status: got %h exp 00408003", rd); end
      mfc0(CP0_EPC, rd);    checks++; if (rd !== 32'h8000_4000) begin errors++; $display("FAIL exc_over_mtc0 epc: got %h exp 80004000", rd); end
   endtask

   task automatic test_ext_int;
      bus.ext_int = 6'b100001;
      mfc0(CP0_CAUSE, rd); checks++; if (rd[15:8] !== 8'h84) begin errors++; $display("FAIL ext_int ip: got %h exp 84", rd[15:8]); end
      mtc0(CP0_CAUSE, 32'hffff_ffff);
      mfc0(CP0_CAUSE, rd); checks++; if (rd[15:8] !== 8'h87) begin errors++; $display("FAIL cause_sw_ip: got %h exp 87", rd[15:8]); end
      mtc0(CP0_STATUS, 32'h0000_0401);
      mfc0(CP0_STATUS, rd); checks++; if (rd !== 32'h0040_0401) begin errors++; $display("FAIL status_write: got %h exp 00400401", rd); end
      checks++; if (bus.int_pending !== 1'b1) begin errors++; $display("FAIL ext_int_pending: got %b exp 1", bus.int_pending); end
      bus.ext_int = 6'b0;
      #1;
      checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL ext_int_masked: got %b exp 0", bus.int_pending); end
      tick;
   endtask

   task automatic test_reset_mid_redirect;
      drive_exc(32'h8000_7000, 1'b0, CODE_ADES, 32'h1234_5678);
      tick;
      bus.exc = '0;
      checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL pre_reset redirect_valid: got %b exp 1", bus.redirect_valid); end
      reset = 1'b1;
      #1;
      check_reset_regs("reset_mid_redirect");
      tick;
      reset = 1'b0;
      tick;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.exc = '0; bus.eret = 1'b0; bus.ext_int = 6'b0;
      bus.raddr = 5'd0; bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
      test_reset;
      test_exc_first;
      test_exc_nested;
      test_eret_priority;
      test_count;
      test_timer_irq;
      test_redirect_ignore;
      test_ext_int;
      test_reset_mid_redirect;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
